// File: rtl/jk_flip_flop.sv
// jk_flip_flop: vectorised positive-edge JK flip-flop with complementary outputs
module jk_flip_flop #(
   parameter int WIDTH = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             clk,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   input  logic             rst_n
);
   logic [WIDTH-1:0] q_next;
   // set and reset are written without q so they resolve an unknown bit
   assign q_next = (j & ~k) | (~j & ~k & q) | (j & k & ~q);
   always_ff @(posedge clk)
      q <= !rst_n ? RESET_VALUE : q_next;
   assign qbar = ~q;
endmodule

// File: tb/tb_jk_flip_flop.sv
// tb_jk_flip_flop: directed checks of a single JK cell and a 4-bit vector with non-zero reset value
module tb_jk_flip_flop;
   logic clk = 1'b0;
   logic rst_n;
   logic j1, k1, q1, qb1;
   logic [3:0] j4, k4, q4, qb4;
   int n = 0;
   int errs = 0;

   jk_flip_flop u1 (.j(j1), .k(k1), .clk(clk), .q(q1), .qbar(qb1), .rst_n(rst_n));
   jk_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010)) u4 (.j(j4), .k(k4), .clk(clk), .q(q4), .qbar(qb4), .rst_n(rst_n));

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step1(input string tag, input logic jv, input logic kv, input logic qe);
      j1 = jv;
      k1 = kv;
      tick();
      chk(tag, {3'b0, q1}, {3'b0, qe});
      chk({tag, "_qbar"}, {3'b0, qb1}, {3'b0, ~qe});
   endtask

   initial begin
      rst_n = 1'b0;
      j1 = 1'b1; k1 = 1'b1;
      j4 = 4'b1111; k4 = 4'b1111;
      tick();
      chk("rst1_q", {3'b0, q1}, 4'b0000);
      chk("rst1_qbar", {3'b0, qb1}, 4'b0001);
      chk("rst1_q4", q4, 4'b1010);
      tick();
      chk("rst2_q", {3'b0, q1}, 4'b0000);
      chk("rst2_q4", q4, 4'b1010);
      rst_n = 1'b1;
      j4 = 4'b0000; k4 = 4'b0000;
      step1("rel_hold", 1'b0, 1'b0, 1'b0);
      step1("pre_set", 1'b1, 1'b0, 1'b1);
      step1("seq_01", 1'b0, 1'b1, 1'b0);
      step1("seq_00a", 1'b0, 1'b0, 1'b0);
      step1("seq_10", 1'b1, 1'b0, 1'b1);
      step1("seq_00b", 1'b0, 1'b0, 1'b1);
      step1("seq_11", 1'b1, 1'b1, 1'b0);
      step1("seq_00c", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      step1("div_rst", 1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++)
         step1($sformatf("div_%0d", i), 1'b1, 1'b1, (i % 2 == 0));
      step1("smp_hold", 1'b0, 1'b0, 1'b0);
      #5 j1 = 1'b1;
      #5 j1 = 1'b0;
      tick();
      chk("smp_pulse", {3'b0, q1}, 4'b0000);
      step1("smp_edge", 1'b1, 1'b0, 1'b1);
      step1("smp_after", 1'b0, 1'b0, 1'b1);
      step1("tog_a", 1'b1, 1'b1, 1'b0);
      step1("tog_b", 1'b1, 1'b1, 1'b1);
      rst_n = 1'b0;
      step1("tog_rst", 1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      step1("tog_resume", 1'b1, 1'b1, 1'b1);
      rst_n = 1'b0;
      tick();
      chk("w_rst_q", q4, 4'b1010);
      chk("w_rst_qbar", qb4, 4'b0101);
      rst_n = 1'b1;
      j4 = 4'b0011; k4 = 4'b0101;
      tick();
      chk("w_mix_q", q4, 4'b1011);
      chk("w_mix_qbar", qb4, 4'b0100);
      tick();
      chk("w_mix2_q", q4, 4'b1010);
      chk("w_mix2_qbar", qb4, 4'b0101);
      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule
